// File: rtl/haar_rom_arbiter.sv
// Two-requester round-robin arbiter for a shared ROM with a fixed read latency.
// Each grant runs one burst of sequential reads; read data returns in order, tagged with its owner.
module haar_rom_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int LEN_WIDTH    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [LEN_WIDTH-1:0]  len0,
  input  logic [LEN_WIDTH-1:0]  len1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = {LEN_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  logic                    gnt0_r;
  logic                    gnt1_r;
  logic                    last_r;
  logic                    owner_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [LEN_WIDTH-1:0]    cnt_r;
  logic [READ_LATENCY-1:0] vld_r;
  logic [READ_LATENCY-1:0] lst_r;

  logic                    any_req_s;
  logic                    pick1_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [LEN_WIDTH-1:0]    sel_len_s;
  logic                    issue_s;
  logic                    last_word_s;
  logic                    zero_done_s;
  logic                    done_s;

  // Round-robin choice: on contention serve whoever was not served last.
  always_comb begin
    any_req_s  = req0 | req1;
    pick1_s    = 1'b0;
    sel_addr_s = addr0;
    sel_len_s  = len0;
    if (req0 && req1) begin
      pick1_s = ~last_r;
    end else if (req1) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    if (pick1_s) begin
      sel_addr_s = addr1;
      sel_len_s  = len1;
    end else begin
      sel_addr_s = addr0;
      sel_len_s  = len0;
    end
  end

  assign issue_s     = (state_r == ISSUE);
  assign last_word_s = (cnt_r == len_r);
  // A grant cycle spent in DRAIN can only be a zero-length burst.
  assign zero_done_s = (state_r == DRAIN) && (gnt0_r || gnt1_r);
  assign done_s      = lst_r[READ_LATENCY-1];

  // Burst sequencer: grant, address issue and drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      last_r  <= 1'b1;
      owner_r <= 1'b0;
      addr_r  <= ADDR_ZERO;
      len_r   <= LEN_ZERO;
      cnt_r   <= LEN_ZERO;
    end else begin
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            gnt0_r  <= ~pick1_s;
            gnt1_r  <= pick1_s;
            last_r  <= pick1_s;
            owner_r <= pick1_s;
            len_r   <= sel_len_s;
            cnt_r   <= LEN_ONE;
            if (sel_len_s != LEN_ZERO) begin
              addr_r  <= sel_addr_s;
              state_r <= ISSUE;
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (last_word_s) begin
            state_r <= DRAIN;
          end else begin
            addr_r <= addr_r + ADDR_ONE;
            cnt_r  <= cnt_r + LEN_ONE;
          end
        end
        DRAIN: begin
          if (done_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Read-return pipeline matching the ROM latency; the last stage drives rd_valid/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= {READ_LATENCY{1'b0}};
      lst_r <= {READ_LATENCY{1'b0}};
    end else begin
      vld_r[0] <= issue_s;
      lst_r[0] <= issue_s && last_word_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        lst_r[i] <= lst_r[i-1];
      end
      // Zero-length bursts report done one cycle after grant, bypassing the ROM latency.
      if (zero_done_s) begin
        lst_r[READ_LATENCY-1] <= 1'b1;
      end
    end
  end

  assign gnt0        = gnt0_r;
  assign gnt1        = gnt1_r;
  assign rom_address = addr_r;
  assign rd_valid    = vld_r[READ_LATENCY-1];
  assign done        = done_s;
  assign rd_id       = owner_r;
  assign rd_data     = rom_q;

endmodule

// File: tb/tb_haar_rom_arbiter.sv
// Directed self-checking bench for haar_rom_arbiter at READ_LATENCY 1 and 3.
module tb_haar_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1;
  logic [11:0] addr0, addr1;
  logic [3:0]  len0, len1;
  logic        gnt0, gnt1, rd_valid, rd_id, done;
  logic [11:0] rom_address;
  logic [7:0]  rom_q, rd_data;

  logic        req0_b, req1_b;
  logic [11:0] addr0_b, addr1_b;
  logic [3:0]  len0_b, len1_b;
  logic        gnt0_b, gnt1_b, rd_valid_b, rd_id_b, done_b;
  logic [11:0] rom_address_b;
  logic [7:0]  rom_q_b, rd_data_b, rom_p0_b, rom_p1_b;

  int n_cmp = 0;
  int n_err = 0;

  haar_rom_arbiter #(.READ_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .rom_address(rom_address), .rom_q(rom_q),
    .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .done(done)
  );

  haar_rom_arbiter #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0(req0_b), .req1(req1_b), .addr0(addr0_b), .addr1(addr1_b), .len0(len0_b), .len1(len1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .rom_address(rom_address_b), .rom_q(rom_q_b),
    .rd_valid(rd_valid_b), .rd_id(rd_id_b), .rd_data(rd_data_b), .done(done_b)
  );

  function automatic logic [7:0] romf(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) rom_q <= romf(rom_address);

  always @(posedge clk) begin
    rom_p0_b <= romf(rom_address_b);
    rom_p1_b <= rom_p0_b;
    rom_q_b  <= rom_p1_b;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and compare one cycle of outputs; ctl = {gnt0,gnt1,rd_valid,done,rd_id}.
  task automatic exp_cyc(input bit use_b, input string tag, input logic g0, input logic g1,
                         input logic [11:0] ea, input logic v, input logic [7:0] d,
                         input logic dn, input logic id);
    logic [4:0]  ctl;
    logic [11:0] ra;
    logic [7:0]  rd;
    @(negedge clk);
    if (use_b) begin
      ctl = {gnt0_b, gnt1_b, rd_valid_b, done_b, rd_id_b};
      ra  = rom_address_b;
      rd  = rd_data_b;
    end else begin
      ctl = {gnt0, gnt1, rd_valid, done, rd_id};
      ra  = rom_address;
      rd  = rd_data;
    end
    check_eq({tag, ".ctl"}, 32'(ctl), 32'({g0, g1, v, dn, id}));
    check_eq({tag, ".addr"}, 32'(ra), 32'(ea));
    if (v) check_eq({tag, ".data"}, 32'(rd), 32'(d));
  endtask

  int g_owner [0:3];
  int g_cyc   [0:3];
  int ng, first_done, both, stray;

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; addr0 = 12'h000; addr1 = 12'h000; len0 = 4'd0; len1 = 4'd0;
    req0_b = 1'b0; req1_b = 1'b0; addr0_b = 12'h000; addr1_b = 12'h000; len0_b = 4'd0; len1_b = 4'd0;
    repeat (2) @(negedge clk);
    check_eq("rst.ctl", 32'({gnt0, gnt1, rd_valid, done, rd_id}), 32'd0);
    check_eq("rst.addr", 32'(rom_address), 32'd0);
    check_eq("rst3.ctl", 32'({gnt0_b, gnt1_b, rd_valid_b, done_b, rd_id_b}), 32'd0);
    reset = 1'b0;

    // Single burst, latency 1
    req0 = 1'b1; addr0 = 12'h010; len0 = 4'd4;
    exp_cyc(1'b0, "t1c0", 1'b1, 1'b0, 12'h010, 1'b0, 8'h00, 1'b0, 1'b0);
    req0 = 1'b0;
    exp_cyc(1'b0, "t1c1", 1'b0, 1'b0, 12'h011, 1'b1, 8'h4A, 1'b0, 1'b0);
    exp_cyc(1'b0, "t1c2", 1'b0, 1'b0, 12'h012, 1'b1, 8'h4B, 1'b0, 1'b0);
    exp_cyc(1'b0, "t1c3", 1'b0, 1'b0, 12'h013, 1'b1, 8'h48, 1'b0, 1'b0);
    exp_cyc(1'b0, "t1c4", 1'b0, 1'b0, 12'h013, 1'b1, 8'h49, 1'b1, 1'b0);
    exp_cyc(1'b0, "t1c5", 1'b0, 1'b0, 12'h013, 1'b0, 8'h00, 1'b0, 1'b0);

    // Address wrap on requester 1
    req1 = 1'b1; addr1 = 12'hFFE; len1 = 4'd4;
    exp_cyc(1'b0, "wc0", 1'b0, 1'b1, 12'hFFE, 1'b0, 8'h00, 1'b0, 1'b1);
    req1 = 1'b0;
    exp_cyc(1'b0, "wc1", 1'b0, 1'b0, 12'hFFF, 1'b1, 8'hA4, 1'b0, 1'b1);
    exp_cyc(1'b0, "wc2", 1'b0, 1'b0, 12'h000, 1'b1, 8'hA5, 1'b0, 1'b1);
    exp_cyc(1'b0, "wc3", 1'b0, 1'b0, 12'h001, 1'b1, 8'h5A, 1'b0, 1'b1);
    exp_cyc(1'b0, "wc4", 1'b0, 1'b0, 12'h001, 1'b1, 8'h5B, 1'b1, 1'b1);
    exp_cyc(1'b0, "wc5", 1'b0, 1'b0, 12'h001, 1'b0, 8'h00, 1'b0, 1'b1);

    // Zero-length burst: no ROM access, done one cycle after grant
    req0 = 1'b1; addr0 = 12'h123; len0 = 4'd0;
    exp_cyc(1'b0, "zc0", 1'b1, 1'b0, 12'h001, 1'b0, 8'h00, 1'b0, 1'b0);
    req0 = 1'b0;
    exp_cyc(1'b0, "zc1", 1'b0, 1'b0, 12'h001, 1'b0, 8'h00, 1'b1, 1'b0);
    exp_cyc(1'b0, "zc2", 1'b0, 1'b0, 12'h001, 1'b0, 8'h00, 1'b0, 1'b0);

    // Contention from reset, both requests held high
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 12'h020; addr1 = 12'h040; len0 = 4'd2; len1 = 4'd2;
    @(negedge clk);
    check_eq("c.rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    reset = 1'b0;
    ng = 0; first_done = -1; both = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if (gnt0 || gnt1) begin
        if (ng < 4) begin
          g_owner[ng] = gnt1 ? 1 : 0;
          g_cyc[ng]   = c;
        end
        ng++;
      end
      if (done && first_done < 0) first_done = c;
    end
    req0 = 1'b0; req1 = 1'b0;
    check_eq("c.ngrants", 32'(ng), 32'd3);
    check_eq("c.both", 32'(both), 32'd0);
    check_eq("c.first_owner", 32'(g_owner[0]), 32'd0);
    check_eq("c.first_cyc", 32'(g_cyc[0]), 32'd0);
    check_eq("c.second_owner", 32'(g_owner[1]), 32'd1);
    check_eq("c.third_owner", 32'(g_owner[2]), 32'd0);
    check_eq("c.first_done", 32'(first_done), 32'd2);
    check_eq("c.gap", 32'(g_cyc[1] - first_done), 32'd2);
    check_eq("c.third_cyc", 32'(g_cyc[2]), 32'd8);
    repeat (2) @(negedge clk);

    // Reset in the middle of a long burst
    req0 = 1'b1; addr0 = 12'h100; len0 = 4'd8;
    exp_cyc(1'b0, "mc0", 1'b1, 1'b0, 12'h100, 1'b0, 8'h00, 1'b0, 1'b0);
    req0 = 1'b0;
    exp_cyc(1'b0, "mc1", 1'b0, 1'b0, 12'h101, 1'b1, 8'h5A, 1'b0, 1'b0);
    exp_cyc(1'b0, "mc2", 1'b0, 1'b0, 12'h102, 1'b1, 8'h5B, 1'b0, 1'b0);
    exp_cyc(1'b0, "mc3", 1'b0, 1'b0, 12'h103, 1'b1, 8'h58, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("m.rst_ctl", 32'({gnt0, gnt1, rd_valid, done, rd_id}), 32'd0);
    check_eq("m.rst_addr", 32'(rom_address), 32'd0);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rd_valid || done || gnt0 || gnt1) stray++;
    end
    check_eq("m.stray", 32'(stray), 32'd0);
    req1 = 1'b1; addr1 = 12'h055; len1 = 4'd1;
    exp_cyc(1'b0, "nc0", 1'b0, 1'b1, 12'h055, 1'b0, 8'h00, 1'b0, 1'b1);
    req1 = 1'b0;
    exp_cyc(1'b0, "nc1", 1'b0, 1'b0, 12'h055, 1'b1, 8'h0F, 1'b1, 1'b1);
    exp_cyc(1'b0, "nc2", 1'b0, 1'b0, 12'h055, 1'b0, 8'h00, 1'b0, 1'b1);

    // Latency sweep: same single burst against the READ_LATENCY=3 instance
    req0_b = 1'b1; addr0_b = 12'h010; len0_b = 4'd4;
    exp_cyc(1'b1, "sc0", 1'b1, 1'b0, 12'h010, 1'b0, 8'h00, 1'b0, 1'b0);
    req0_b = 1'b0;
    exp_cyc(1'b1, "sc1", 1'b0, 1'b0, 12'h011, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_cyc(1'b1, "sc2", 1'b0, 1'b0, 12'h012, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_cyc(1'b1, "sc3", 1'b0, 1'b0, 12'h013, 1'b1, 8'h4A, 1'b0, 1'b0);
    exp_cyc(1'b1, "sc4", 1'b0, 1'b0, 12'h013, 1'b1, 8'h4B, 1'b0, 1'b0);
    exp_cyc(1'b1, "sc5", 1'b0, 1'b0, 12'h013, 1'b1, 8'h48, 1'b0, 1'b0);
    exp_cyc(1'b1, "sc6", 1'b0, 1'b0, 12'h013, 1'b1, 8'h49, 1'b1, 1'b0);
    exp_cyc(1'b1, "sc7", 1'b0, 1'b0, 12'h013, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

endmodule
